// File: rtl/sound_event_sequencer.sv
// Sound event sequencer: turns game event strobes into fixed square-wave note sequences.
// Latency: an event loads on the next cycle; sample/sample_valid follow sample_req by one cycle.
// Backpressure: none; every request is served, busy events preempt, queue one-deep or drop.
module sound_event_sequencer #(
  parameter int unsigned        MS_DIV    = 50000,
  parameter logic signed [15:0] AMPLITUDE = 16'sd8192,
  parameter int unsigned        GAP_MS    = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wall_hit,
  input  logic               paddle_hit,
  input  logic               point,
  input  logic               lvl_up,
  input  logic               win,
  input  logic               mute,
  input  logic               sample_req,
  output logic signed [15:0] sample,
  output logic               sample_valid,
  output logic               busy,
  output logic [2:0]         cur_event
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_NOTE = 2'd1, ST_GAP = 2'd2} state_t;

  localparam logic [15:0] PRE_LAST = 16'(MS_DIV - 1);
  localparam logic [8:0]  GAP_LAST = 9'(GAP_MS - 1);

  state_t             state_q, state_d;
  logic [2:0]         cur_q, pending_q, pending_d;
  logic [2:0]         evt_new, start_evt, start_pend, load_evt;
  logic [1:0]         idx_q, last_idx;
  logic               phase_q;
  logic [16:0]        hp_cnt_q, note_hp;
  logic [15:0]        pre_cnt_q;
  logic [8:0]         ms_cnt_q, note_ms;
  logic               ms_wrap, note_done, gap_done, seq_end;
  logic               load, seg_gap, seg_next, seq_idle;
  logic signed [15:0] tone_val;

  // Note table: half-period (clk cycles at 50 MHz) and duration (ms) of the current note
  always_comb begin
    note_hp  = 17'd1;
    note_ms  = 9'd1;
    last_idx = 2'd0;
    case (cur_q)
      3'd1: begin
        note_hp = 17'd56818;
        note_ms = 9'd40;
      end
      3'd2: begin
        note_hp = 17'd28409;
        note_ms = 9'd40;
      end
      3'd3: begin
        last_idx = 2'd1;
        note_ms  = 9'd100;
        note_hp  = (idx_q == 2'd0) ? 17'd47801 : 17'd63776;
      end
      3'd4: begin
        last_idx = 2'd2;
        note_ms  = 9'd80;
        case (idx_q)
          2'd0:    note_hp = 17'd47801;
          2'd1:    note_hp = 17'd37936;
          default: note_hp = 17'd31888;
        endcase
      end
      3'd5: begin
        last_idx = 2'd3;
        case (idx_q)
          2'd0: begin
            note_hp = 17'd47801;
            note_ms = 9'd150;
          end
          2'd1: begin
            note_hp = 17'd37936;
            note_ms = 9'd150;
          end
          2'd2: begin
            note_hp = 17'd31888;
            note_ms = 9'd150;
          end
          default: begin
            note_hp = 17'd23878;
            note_ms = 9'd300;
          end
        endcase
      end
      default: ;
    endcase
  end

  // Fixed-priority pick among simultaneous event pulses; lower ones are dropped
  always_comb begin
    if (win)             evt_new = 3'd5;
    else if (lvl_up)     evt_new = 3'd4;
    else if (point)      evt_new = 3'd3;
    else if (paddle_hit) evt_new = 3'd2;
    else if (wall_hit)   evt_new = 3'd1;
    else                 evt_new = 3'd0;
  end

  // When starting from idle (or at sequence end) a new event competes with pending;
  // a losing pending survives, a losing new event is dropped (pending wins ties)
  assign start_evt  = (evt_new > pending_q) ? evt_new : pending_q;
  assign start_pend = (evt_new > pending_q) ? pending_q : 3'd0;

  assign ms_wrap   = (pre_cnt_q == PRE_LAST);
  assign note_done = (state_q == ST_NOTE) && ms_wrap && (ms_cnt_q == note_ms - 9'd1);
  assign gap_done  = (state_q == ST_GAP) && ms_wrap && (ms_cnt_q == GAP_LAST);
  assign seq_end   = gap_done && (idx_q == last_idx);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and sequencing decisions
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    load      = 1'b0;
    load_evt  = cur_q;
    seg_gap   = 1'b0;
    seg_next  = 1'b0;
    seq_idle  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_evt != 3'd0) begin
          load      = 1'b1;
          load_evt  = start_evt;
          pending_d = start_pend;
          state_d   = ST_NOTE;
        end
      end
      ST_NOTE, ST_GAP: begin
        if (seq_end) begin
          if (start_evt != 3'd0) begin
            load      = 1'b1;
            load_evt  = start_evt;
            pending_d = start_pend;
            state_d   = ST_NOTE;
          end else begin
            seq_idle = 1'b1;
            state_d  = ST_IDLE;
          end
        end else if (evt_new > cur_q) begin
          // Preempt: the interrupted sequence is discarded
          load     = 1'b1;
          load_evt = evt_new;
          state_d  = ST_NOTE;
        end else begin
          if (evt_new > pending_q) pending_d = evt_new;
          if (note_done) begin
            seg_gap = 1'b1;
            state_d = ST_GAP;
          end else if (gap_done) begin
            seg_next = 1'b1;
            state_d  = ST_NOTE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs derived from state: busy flag and the tone level feeding the sample register
  always_comb begin
    busy     = (state_q != ST_IDLE);
    tone_val = 16'sd0;
    if ((state_q == ST_NOTE) && !mute) tone_val = phase_q ? AMPLITUDE : -AMPLITUDE;
  end

  assign cur_event = cur_q;

  // Sequence datapath: event, pending slot, note index, tone phase and timing counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_q     <= 3'd0;
      pending_q <= 3'd0;
      idx_q     <= 2'd0;
      phase_q   <= 1'b0;
      hp_cnt_q  <= 17'd0;
      pre_cnt_q <= 16'd0;
      ms_cnt_q  <= 9'd0;
    end else begin
      pending_q <= pending_d;
      if (load || seq_idle || seg_next || seg_gap) begin
        // Every segment boundary restarts timing; each note starts at phase 0
        phase_q   <= 1'b0;
        hp_cnt_q  <= 17'd0;
        pre_cnt_q <= 16'd0;
        ms_cnt_q  <= 9'd0;
        if (load) begin
          cur_q <= load_evt;
          idx_q <= 2'd0;
        end else if (seq_idle) begin
          cur_q <= 3'd0;
          idx_q <= 2'd0;
        end else if (seg_next) begin
          idx_q <= idx_q + 2'd1;
        end
      end else if (state_q != ST_IDLE) begin
        if (ms_wrap) begin
          pre_cnt_q <= 16'd0;
          ms_cnt_q  <= ms_cnt_q + 9'd1;
        end else begin
          pre_cnt_q <= pre_cnt_q + 16'd1;
        end
        if (state_q == ST_NOTE) begin
          if (hp_cnt_q == note_hp - 17'd1) begin
            hp_cnt_q <= 17'd0;
            phase_q  <= ~phase_q;
          end else begin
            hp_cnt_q <= hp_cnt_q + 17'd1;
          end
        end
      end
    end
  end

  // Sample register: capture the tone level on each request, strobe valid for one cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample       <= 16'sd0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= sample_req;
      if (sample_req) sample <= tone_val;
    end
  end

endmodule

// File: tb/tb_sound_event_sequencer.sv
// Bench for sound_event_sequencer: vector table, hand sequences, randomized run vs model.
// A second instance with a long ms tick exercises square-wave phase toggling.
// Outputs are sampled on the falling edge or 2 ns after the rising edge.
module tb_sound_event_sequencer;

  localparam int MS_DIV_T    = 20;
  localparam int GAP_MS_T    = 10;
  localparam int MS_DIV_TONE = 1500;
  localparam int AMP         = 8192;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic [4:0]         ev;
  logic               reset, mute, sample_req;
  logic               wall_hit, paddle_hit, point, lvl_up, win;
  logic signed [15:0] sample;
  logic               sample_valid, busy;
  logic [2:0]         cur_event;

  logic               t_reset, t_paddle, t_mute, t_req;
  logic signed [15:0] t_sample;
  logic               t_valid, t_busy;
  logic [2:0]         t_cur;
  logic               tone_done;

  assign {win, lvl_up, point, paddle_hit, wall_hit} = ev;

  sound_event_sequencer #(.MS_DIV(MS_DIV_T), .AMPLITUDE(16'sd8192), .GAP_MS(GAP_MS_T)) dut (
    .clk(clk), .reset(reset), .wall_hit(wall_hit), .paddle_hit(paddle_hit), .point(point),
    .lvl_up(lvl_up), .win(win), .mute(mute), .sample_req(sample_req), .sample(sample),
    .sample_valid(sample_valid), .busy(busy), .cur_event(cur_event)
  );

  sound_event_sequencer #(.MS_DIV(MS_DIV_TONE), .AMPLITUDE(16'sd8192), .GAP_MS(GAP_MS_T)) dut_tone (
    .clk(clk), .reset(t_reset), .wall_hit(1'b0), .paddle_hit(t_paddle), .point(1'b0),
    .lvl_up(1'b0), .win(1'b0), .mute(t_mute), .sample_req(t_req), .sample(t_sample),
    .sample_valid(t_valid), .busy(t_busy), .cur_event(t_cur)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model: a sequence is a queue of timed segments -------------
  int mq_hp[$];   // 0 marks a silent gap
  int mq_len[$];  // segment length in clk cycles
  int m_age, m_cur, m_pend, exp_sample, exp_valid;
  bit model_on = 1'b0;

  function automatic int ev_code(input logic [4:0] v);
    for (int b = 4; b >= 0; b--) if (v[b]) return b + 1;
    return 0;
  endfunction

  function automatic void m_load(input int e);
    int hps[$];
    int mss[$];
    case (e)
      1: begin hps = '{56818}; mss = '{40}; end
      2: begin hps = '{28409}; mss = '{40}; end
      3: begin hps = '{47801, 63776}; mss = '{100, 100}; end
      4: begin hps = '{47801, 37936, 31888}; mss = '{80, 80, 80}; end
      default: begin hps = '{47801, 37936, 31888, 23878}; mss = '{150, 150, 150, 300}; end
    endcase
    mq_hp.delete();
    mq_len.delete();
    foreach (hps[i]) begin
      mq_hp.push_back(hps[i]);
      mq_len.push_back(mss[i] * MS_DIV_T);
      mq_hp.push_back(0);
      mq_len.push_back(GAP_MS_T * MS_DIV_T);
    end
    m_age = 0;
    m_cur = e;
  endfunction

  function automatic void m_reset();
    mq_hp.delete();
    mq_len.delete();
    m_age = 0; m_cur = 0; m_pend = 0; exp_sample = 0; exp_valid = 0;
  endfunction

  function automatic void m_step(input logic [4:0] ev_v, input logic mute_v, input logic req_v);
    int  e;
    int  tone;
    bit  active, ending;
    e      = ev_code(ev_v);
    tone   = 0;
    active = (mq_hp.size() > 0);
    if (active && mq_hp[0] != 0 && !mute_v) tone = (((m_age / mq_hp[0]) % 2) == 1) ? AMP : -AMP;
    exp_valid = req_v ? 1 : 0;
    if (req_v) exp_sample = tone;
    ending = active && (mq_hp.size() == 1) && (m_age == mq_len[0] - 1);
    if (!active || ending) begin
      if (e > m_pend) m_load(e);
      else if (m_pend != 0) begin m_load(m_pend); m_pend = 0; end
      else begin mq_hp.delete(); mq_len.delete(); m_cur = 0; m_age = 0; end
    end else if (e > m_cur) begin
      m_load(e);
    end else begin
      if (e > m_pend) m_pend = e;
      m_age++;
      if (m_age == mq_len[0]) begin
        void'(mq_hp.pop_front());
        void'(mq_len.pop_front());
        m_age = 0;
      end
    end
  endfunction

  always begin
    @(posedge clk);
    if (model_on) begin
      m_step(ev, mute, sample_req);
      #2;
      chk("model busy", busy, (mq_hp.size() > 0) ? 1 : 0);
      chk("model cur_event", cur_event, m_cur);
      chk("model sample_valid", sample_valid, exp_valid);
      chk("model sample", sample, exp_sample);
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [4:0] ev;
    logic       mute;
    logic       req;
    int         skip;
    int         e_busy;
    int         e_cur;
    int         e_valid;
    int         e_sample;
  } vec_t;

  vec_t tbl[20];

  task automatic apply_vec(input vec_t v, input int idx);
    ev = v.ev; mute = v.mute; sample_req = v.req;
    @(negedge clk);
    ev = 5'd0; sample_req = 1'b0;
    repeat (v.skip) @(negedge clk);
    chk($sformatf("vec%0d busy", idx), busy, v.e_busy);
    chk($sformatf("vec%0d cur_event", idx), cur_event, v.e_cur);
    chk($sformatf("vec%0d sample_valid", idx), sample_valid, v.e_valid);
    chk($sformatf("vec%0d sample", idx), sample, v.e_sample);
  endtask

  // ---------------- tone instance: phase toggling and mute on a long note ----------------
  typedef struct { int k; logic m; int s; } cp_t;

  initial begin
    cp_t cps[9];
    int  tc;
    cps[0] = '{0, 1'b0, -AMP};     cps[1] = '{28408, 1'b0, -AMP};
    cps[2] = '{28409, 1'b0, AMP};  cps[3] = '{30000, 1'b1, 0};
    cps[4] = '{30001, 1'b0, AMP};  cps[5] = '{56817, 1'b0, AMP};
    cps[6] = '{56818, 1'b0, -AMP}; cps[7] = '{59999, 1'b0, -AMP};
    cps[8] = '{60000, 1'b0, 0};
    tone_done = 1'b0;
    t_reset = 1'b0; t_paddle = 1'b0; t_mute = 1'b0; t_req = 1'b0;
    repeat (3) @(negedge clk);
    t_reset = 1'b1;
    @(negedge clk);
    t_paddle = 1'b1;
    @(negedge clk);
    t_paddle = 1'b0;
    tc = 1;
    chk("tone busy after pulse", t_busy, 1);
    chk("tone cur_event", t_cur, 2);
    foreach (cps[i]) begin
      while (tc < cps[i].k + 1) begin
        @(negedge clk);
        tc++;
      end
      t_mute = cps[i].m;
      t_req  = 1'b1;
      @(negedge clk);
      tc++;
      t_req  = 1'b0;
      t_mute = 1'b0;
      chk($sformatf("tone k=%0d valid", cps[i].k), t_valid, 1);
      chk($sformatf("tone k=%0d sample", cps[i].k), t_sample, cps[i].s);
    end
    chk("tone busy in gap", t_busy, 1);
    tone_done = 1'b1;
  end

  // ---------------- main sequence ----------------
  initial begin
    // ev, mute, req, skip, busy, cur, valid, sample
    tbl[0]  = '{5'b00000, 1'b0, 1'b1, 0,     0, 0, 1, 0};
    tbl[1]  = '{5'b00001, 1'b0, 1'b0, 0,     1, 1, 0, 0};
    tbl[2]  = '{5'b00000, 1'b0, 1'b1, 0,     1, 1, 1, -AMP};
    tbl[3]  = '{5'b00000, 1'b1, 1'b1, 0,     1, 1, 1, 0};
    tbl[4]  = '{5'b00000, 1'b0, 1'b1, 996,   1, 1, 0, -AMP};
    tbl[5]  = '{5'b00000, 1'b0, 1'b1, 0,     0, 0, 1, 0};
    tbl[6]  = '{5'b00110, 1'b0, 1'b0, 0,     1, 3, 0, 0};
    tbl[7]  = '{5'b00000, 1'b0, 1'b0, 4398,  1, 3, 0, 0};
    tbl[8]  = '{5'b00000, 1'b0, 1'b0, 0,     0, 0, 0, 0};
    tbl[9]  = '{5'b00010, 1'b0, 1'b0, 0,     1, 2, 0, 0};
    tbl[10] = '{5'b01000, 1'b0, 1'b0, 0,     1, 4, 0, 0};
    tbl[11] = '{5'b00000, 1'b0, 1'b0, 5398,  1, 4, 0, 0};
    tbl[12] = '{5'b00000, 1'b0, 1'b0, 0,     0, 0, 0, 0};
    tbl[13] = '{5'b10000, 1'b0, 1'b0, 0,     1, 5, 0, 0};
    tbl[14] = '{5'b00100, 1'b0, 1'b0, 10,    1, 5, 0, 0};
    tbl[15] = '{5'b01000, 1'b0, 1'b0, 0,     1, 5, 0, 0};
    tbl[16] = '{5'b00000, 1'b0, 1'b0, 15786, 1, 5, 0, 0};
    tbl[17] = '{5'b00000, 1'b0, 1'b0, 0,     1, 4, 0, 0};
    tbl[18] = '{5'b00000, 1'b0, 1'b0, 5398,  1, 4, 0, 0};
    tbl[19] = '{5'b00000, 1'b0, 1'b0, 0,     0, 0, 0, 0};

    ev = 5'd0; mute = 1'b0; sample_req = 1'b0; reset = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset cur_event", cur_event, 0);
    chk("reset sample_valid", sample_valid, 0);
    chk("reset sample", sample, 0);
    reset = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) apply_vec(tbl[i], i);

    // Asynchronous reset in the middle of a win note
    ev = 5'b10000;
    @(negedge clk);
    ev = 5'd0;
    repeat (100) @(negedge clk);
    sample_req = 1'b1;
    @(negedge clk);
    sample_req = 1'b0;
    chk("pre-reset valid", sample_valid, 1);
    chk("pre-reset sample", sample, -AMP);
    #3 reset = 1'b0;
    #1;
    chk("async reset busy", busy, 0);
    chk("async reset cur_event", cur_event, 0);
    chk("async reset sample_valid", sample_valid, 0);
    chk("async reset sample", sample, 0);
    @(negedge clk);
    reset = 1'b1;
    sample_req = 1'b1;
    @(negedge clk);
    sample_req = 1'b0;
    chk("post-reset valid", sample_valid, 1);
    chk("post-reset sample", sample, 0);
    chk("post-reset busy", busy, 0);
    @(negedge clk);
    chk("post-reset valid drop", sample_valid, 0);

    // Event arriving on the exact sequence-end edge competes with pending
    m_reset();
    model_on = 1'b1;
    ev = 5'b00100;
    @(negedge clk);
    ev = 5'd0;
    repeat (49) @(negedge clk);
    ev = 5'b00001;
    @(negedge clk);
    ev = 5'd0;
    repeat (4349) @(negedge clk);
    ev = 5'b00010;
    @(negedge clk);
    ev = 5'd0;
    chk("end-edge new event wins", cur_event, 2);
    repeat (1000) @(negedge clk);
    chk("end-edge pending kept", cur_event, 1);
    repeat (1010) @(negedge clk);
    chk("end-edge all done", busy, 0);

    // Randomized traffic against the model
    for (int c = 0; c < 15000; c++) begin
      ev = ($urandom_range(0, 299) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      sample_req = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 499) == 0) mute = ~mute;
      @(negedge clk);
    end
    ev = 5'd0; sample_req = 1'b0; mute = 1'b0;
    @(negedge clk);
    model_on = 1'b0;

    for (int w = 0; w < 20000 && !tone_done; w++) @(negedge clk);
    chk("tone test completed", tone_done, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
